// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared types and constants for the fdiv issue stage: FSM state
//            encoding, exception-flag bit positions, format selectors and the
//            half-format operand masking helper.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Issue-stage FSM states, explicitly sized and encoded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // mode_fp encoding
  localparam logic FMT_SINGLE = 1'b1;
  localparam logic FMT_HALF   = 1'b0;

  // Half-format values only carry [15:0]; the upper half is zeroed
  function automatic logic [31:0] fmt_mask(input logic [31:0] x, input logic fp);
    return (fp == FMT_SINGLE) ? x : {16'h0000, x[15:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_issue_stage_if
// Purpose  : Request, fdiv-side, response and sticky-flag signals of the
//            fdiv issue stage. The slave modport is the stage itself, the
//            master modport is its environment (upstream, fdiv, downstream).
// Revision : 1.0 - initial release
// ============================================================================
interface fdiv_issue_stage_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_rm;
  logic        req_fp;

  logic [31:0] div_op_a;
  logic [31:0] div_op_b;
  logic        div_rm;
  logic        div_fp;
  logic [31:0] div_result;
  logic [4:0]  div_flags;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;

  logic [4:0]  fflags;
  logic        fflags_clr;

  modport slave (
    input  req_valid, req_a, req_b, req_rm, req_fp,
    input  div_result, div_flags,
    input  rsp_ready, fflags_clr,
    output req_ready, div_op_a, div_op_b, div_rm, div_fp,
    output rsp_valid, rsp_result, rsp_flags, fflags
  );

  modport master (
    output req_valid, req_a, req_b, req_rm, req_fp,
    output div_result, div_flags,
    output rsp_ready, fflags_clr,
    input  req_ready, div_op_a, div_op_b, div_rm, div_fp,
    input  rsp_valid, rsp_result, rsp_flags, fflags
  );

endinterface
`default_nettype wire

// File: rtl/fflags_acc.sv
`default_nettype none
// ============================================================================
// Module   : fflags_acc
// Purpose  : Sticky exception-flag accumulator. Each delivered response ORs
//            its flags in; a clear wins over the OR but keeps the flags of a
//            response delivered in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fflags_acc (
  input  wire        clk,
  input  wire        rst,
  input  wire        clr,
  input  wire        hs,
  input  wire  [4:0] flags,
  output logic [4:0] fflags
);

  logic [4:0] fflags_d;
  logic [4:0] fflags_q;

  // Next sticky value: clear has priority, coincident handshake flags survive
  always_comb begin
    fflags_d = fflags_q;
    if (clr) begin
      fflags_d = hs ? flags : 5'b00000;
    end else if (hs) begin
      fflags_d = fflags_q | flags;
    end
  end

  // Sticky register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_q <= 5'b00000;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags = fflags_q;

endmodule
`default_nettype wire

// File: rtl/fdiv_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_issue_stage
// Purpose  : Sequential front-end for the combinational fdiv unit. Registers
//            one request onto the fdiv inputs, holds them for SETTLE_CYC
//            cycles, captures result/flags and offers them downstream.
//            Optional macro FDIV_ISSUE_BYPASS_EN: accept a new request in the
//            same cycle as the response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fdiv_issue_stage
  import fp_pkg::*;
#(
  parameter int SETTLE_CYC = 2,  // legal 1..15
  parameter int CNT_W      = 4   // 2**CNT_W must exceed SETTLE_CYC
) (
  input wire               clk,
  input wire               rst,
  fdiv_issue_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_e           state_d,  state_q;
  logic [CNT_W-1:0] cnt_d,    cnt_q;
  logic [31:0]      op_a_d,   op_a_q;
  logic [31:0]      op_b_d,   op_b_q;
  logic             rm_d,     rm_q;
  logic             fp_d,     fp_q;
  logic [31:0]      res_d,    res_q;
  logic [4:0]       flg_d,    flg_q;

  logic             req_ready_w;
  logic             accept_w;
  logic             rsp_hs_w;

  // Request acceptance: idle always; in DONE only with the bypass option
  always_comb begin
    req_ready_w = (state_q == ST_IDLE);
`ifdef FDIV_ISSUE_BYPASS_EN
    if (state_q == ST_DONE) begin
      req_ready_w = bus.rsp_ready;
    end
`endif
    accept_w = bus.req_valid & req_ready_w;
    rsp_hs_w = (state_q == ST_DONE) & bus.rsp_ready;
  end

  // FSM next state, operand registration, settle counting and capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rm_d    = rm_q;
    fp_d    = fp_q;
    res_d   = res_q;
    flg_d   = flg_q;
    case (state_q)
      ST_EXEC: begin
        if (cnt_q == '0) begin
          res_d   = fmt_mask(bus.div_result, fp_q);
          flg_d   = bus.div_flags;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_hs_w) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
    // A new request (from IDLE, or from DONE with bypass) overrides the above
    if (accept_w) begin
      op_a_d  = fmt_mask(bus.req_a, bus.req_fp);
      op_b_d  = fmt_mask(bus.req_b, bus.req_fp);
      rm_d    = bus.req_rm;
      fp_d    = bus.req_fp;
      cnt_d   = CNT_LOAD;
      state_d = ST_EXEC;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_a_q  <= 32'h0;
      op_b_q  <= 32'h0;
      rm_q    <= 1'b0;
      fp_q    <= 1'b0;
      res_q   <= 32'h0;
      flg_q   <= 5'b00000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rm_q    <= rm_d;
      fp_q    <= fp_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  fflags_acc u_fflags_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.fflags_clr),
    .hs     (rsp_hs_w),
    .flags  (flg_q),
    .fflags (bus.fflags)
  );

  assign bus.req_ready  = req_ready_w;
  assign bus.div_op_a   = op_a_q;
  assign bus.div_op_b   = op_b_q;
  assign bus.div_rm     = rm_q;
  assign bus.div_fp     = fp_q;
  assign bus.rsp_valid  = (state_q == ST_DONE);
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flg_q;

endmodule
`default_nettype wire

// File: tb/tb_fdiv_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fdiv_issue_stage
// Purpose  : Scoreboard bench for fdiv_issue_stage. A behavioural fdiv stub
//            produces garbage until its inputs have been stable for
//            SETTLE_CYC cycles. Accepted requests push expectations; a
//            negedge monitor checks latency, held responses, fdiv inputs and
//            the sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fdiv_issue_stage;

  localparam int S     = 3;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  fdiv_issue_stage_if bus ();

  fdiv_issue_stage #(.SETTLE_CYC(S), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] fmt(input logic [31:0] x, input logic fp);
    return fp ? x : {16'h0000, x[15:0]};
  endfunction

  // Returns {flags, result} of an idealised fdiv
  function automatic logic [36:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic rm, input logic fp);
    logic [31:0] r;
    logic [15:0] lo;
    logic [4:0]  f;
    if (fp) begin
      if (a == 32'h3F800000 && b == 32'h40000000) begin
        r = 32'h3F000000; f = 5'b00000;
      end else if (a == 32'h3F800000 && b == 32'h40400000) begin
        r = 32'h3EAAAAAB; f = 5'b00001;
      end else if (b[30:0] == 31'h0) begin
        r = {a[31] ^ b[31], 31'h7F800000}; f = 5'b01000;
      end else begin
        r = (a ^ {b[7:0], b[31:8]}) + {31'h0, rm};
        f = (a[4:0] ^ b[9:5]) & 5'b10111;
      end
    end else begin
      if (a[15:0] == 16'h3C00 && b[15:0] == 16'h4000) begin
        lo = 16'h3800; f = 5'b00000;
      end else if (b[14:0] == 15'h0) begin
        lo = {a[15] ^ b[15], 15'h7C00}; f = 5'b01000;
      end else begin
        lo = a[15:0] ^ {b[7:0], b[15:8]} ^ {15'h0, rm};
        f  = (a[9:5] ^ b[4:0]) & 5'b10111;
      end
      r = {16'hA5A5, lo};   // half-mode fdiv leaves junk in the upper half
    end
    return {f, r};
  endfunction

  // ---------------- fdiv stub with settle behaviour ----------------
  int          age;
  logic [65:0] prev_in;

  initial begin
    age     = 0;
    prev_in = '0;
    forever begin
      @(negedge clk);
      if ({bus.div_op_a, bus.div_op_b, bus.div_rm, bus.div_fp} !== prev_in) age = 1;
      else if (age < 1000) age++;
      prev_in = {bus.div_op_a, bus.div_op_b, bus.div_rm, bus.div_fp};
    end
  end

  always_comb begin
    logic [36:0] m;
    m = fdiv_ref(bus.div_op_a, bus.div_op_b, bus.div_rm, bus.div_fp);
    if (age >= S) begin
      bus.div_result = m[31:0];
      bus.div_flags  = m[36:32];
    end else begin
      bus.div_result = 32'hBAD0BAD0 ^ m[31:0];
      bus.div_flags  = 5'b11111;
    end
  end

  // ---------------- response-ready driver ----------------
  logic force_rdy;
  logic rand_rdy;

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        rm;
    logic        fp;
    logic [31:0] res;
    logic [4:0]  flg;
    int          acc;
  } exp_t;

  exp_t       q[$];
  logic       seen;
  logic [4:0] mff;

  initial begin
    seen = 1'b0;
    mff  = 5'b00000;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        seen = 1'b0;
        mff  = 5'b00000;
      end else begin
        logic       hs;
        logic [4:0] hflg;
        exp_t       e;
        hs   = 1'b0;
        hflg = 5'b00000;
        chk("fflags", {59'h0, bus.fflags}, {59'h0, mff});
        if (q.size() > 0 && !bus.req_ready) begin
          e = q[0];
          chk("div_op_a", {32'h0, bus.div_op_a}, {32'h0, e.a});
          chk("div_op_b", {32'h0, bus.div_op_b}, {32'h0, e.b});
          chk("div_rm_fp", {62'h0, bus.div_rm, bus.div_fp}, {62'h0, e.rm, e.fp});
        end
        if (bus.rsp_valid) begin
          if (q.size() == 0) begin
            chk("stale_rsp_valid", 64'h1, 64'h0);
          end else begin
            e = q[0];
            if (!seen) begin
              chk("latency", 64'(cyc - e.acc), 64'(S + 1));
              seen = 1'b1;
            end
            chk("rsp_result", {32'h0, bus.rsp_result}, {32'h0, e.res});
            chk("rsp_flags", {59'h0, bus.rsp_flags}, {59'h0, e.flg});
            if (bus.rsp_ready) begin
              hs   = 1'b1;
              hflg = e.flg;
              void'(q.pop_front());
              seen = 1'b0;
            end
          end
        end
        if (bus.fflags_clr) mff = hs ? hflg : 5'b00000;
        else if (hs)        mff = mff | hflg;
        if (bus.req_valid && bus.req_ready) begin
          logic [36:0] m;
          if (q.size() != 0) chk("accept_while_busy", 64'h1, 64'h0);
          e.a   = fmt(bus.req_a, bus.req_fp);
          e.b   = fmt(bus.req_b, bus.req_fp);
          e.rm  = bus.req_rm;
          e.fp  = bus.req_fp;
          m     = fdiv_ref(e.a, e.b, e.rm, e.fp);
          e.res = fmt(m[31:0], e.fp);
          e.flg = m[36:32];
          e.acc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic present(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic fp);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_rm    = rm;
    bus.req_fp    = fp;
    bus.req_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic wait_accept();
    int n;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) chk("accept_timeout", 64'h0, 64'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic fp);
    present(a, b, rm, fp);
    wait_accept();
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rsp_valid) chk("rsp_valid_timeout", 64'h0, 64'h1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !bus.req_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || !bus.req_ready) chk("drain_timeout", 64'h0, 64'h1);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    force_rdy      = 1'b1;
    rand_rdy       = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_a      = 32'h0;
    bus.req_b      = 32'h0;
    bus.req_rm     = 1'b0;
    bus.req_fp     = 1'b0;
    bus.fflags_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_req_ready", {63'h0, bus.req_ready}, 64'h1);
    chk("rst_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
    chk("rst_div_ops", {bus.div_op_a, bus.div_op_b}, 64'h0);
    chk("rst_div_rm_fp", {62'h0, bus.div_rm, bus.div_fp}, 64'h0);
    chk("rst_rsp", {27'h0, bus.rsp_flags, bus.rsp_result}, 64'h0);
    chk("rst_fflags", {59'h0, bus.fflags}, 64'h0);
    rst = 1'b0;

    // fp32 1.0 / 2.0
    send(32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    wait_idle();
    // divide by zero
    send(32'h3F800000, 32'h00000000, 1'b0, 1'b1);
    wait_idle();
    chk("dz_fflags", {59'h0, bus.fflags}, 64'h08);
    // half mode
    send(32'hDEAD3C00, 32'hBEEF4000, 1'b0, 1'b0);
    wait_idle();
    chk("half_div_op_a", {32'h0, bus.div_op_a}, 64'h00003C00);
    chk("half_div_op_b", {32'h0, bus.div_op_b}, 64'h00004000);
    chk("half_rsp_result", {32'h0, bus.rsp_result}, 64'h00003800);

    // backpressure: response held 5 cycles while a second request waits
    force_rdy = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b1, 1'b1);
    wait_rsp_valid();
    present(32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_req_ready", {63'h0, bus.req_ready}, 64'h0);
      chk("bp_rsp_valid", {63'h0, bus.rsp_valid}, 64'h1);
    end
    force_rdy = 1'b1;
    wait_accept();
    wait_idle();

    // clear colliding with a handshake carrying NX
    chk("pre_clr_fflags", {59'h0, bus.fflags}, 64'h08);
    force_rdy = 1'b0;
    send(32'h3F800000, 32'h40400000, 1'b0, 1'b1);
    wait_rsp_valid();
    force_rdy      = 1'b1;
    bus.fflags_clr = 1'b1;
    @(posedge clk); #1;
    bus.fflags_clr = 1'b0;
    chk("clr_collision_fflags", {59'h0, bus.fflags}, 64'h01);
    wait_idle();

    // reset pulsed mid-EXEC
    send(32'h3F800000, 32'h00000000, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_req_ready", {63'h0, bus.req_ready}, 64'h1);
    chk("mid_rst_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
    chk("mid_rst_fflags", {59'h0, bus.fflags}, 64'h0);
    repeat (S + 4) @(posedge clk);
    #1;

    // randomized traffic with random backpressure and clears
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      bus.fflags_clr = ($urandom_range(0, 5) == 0);
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.fflags_clr = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy  = 1'b0;
    force_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fdiv_issue_stage.md
Name: fdiv_issue_stage

Overview:
- Sequential front-end that sits directly upstream of the combinational `fdiv` unit.
- Accepts one divide request at a time over a valid/ready handshake and registers the operands, rounding mode and format.
- Holds those values stable on the `fdiv` inputs for a programmable settle window, then captures `result`/`flags`.
- Presents the captured result downstream over a second valid/ready handshake and maintains a sticky exception-flag register.

Parameters:
- SETTLE_CYC, default 2: cycles the `fdiv` inputs are held before capture (multicycle path budget). Legal range 1..15.
- CNT_W, default 4: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYC.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  stage can accept a request.
- req_a  in  32  dividend; half format uses [15:0], [31:16] ignored.
- req_b  in  32  divisor; same format rule as req_a.
- req_rm  in  1  rounding mode, forwarded to `fdiv.round_mode`.
- req_fp  in  1  1 = single (fp32), 0 = half (fp16); forwarded to `fdiv.mode_fp`.
- div_op_a  out  32  to `fdiv.op_a`.
- div_op_b  out  32  to `fdiv.op_b`.
- div_rm  out  1  to `fdiv.round_mode`.
- div_fp  out  1  to `fdiv.mode_fp`.
- div_result  in  32  from `fdiv.result`.
- div_flags  in  5  from `fdiv.flags`, ordered {NV, DZ, OF, UF, NX}.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  downstream accepts response.
- rsp_result  out  32  captured result; [31:16] forced 0 in half mode.
- rsp_flags  out  5  flags captured with rsp_result.
- fflags  out  5  sticky OR of all delivered rsp_flags.
- fflags_clr  in  1  clear sticky flags.

Behaviour:
- Reset values (synchronous, on clk while rst = 1):
  - state = IDLE.
  - req_ready = 1, rsp_valid = 0.
  - div_op_a, div_op_b, rsp_result = 0.
  - div_rm, div_fp = 0.
  - rsp_flags, fflags = 0.
  - Counter = 0.
- rst asserted mid-EXEC or mid-DONE aborts the operation; the pending response is lost.
- States: IDLE, EXEC, DONE. req_ready = (state == IDLE).
- IDLE:
  - On req_valid & req_ready, register req_a, req_b, req_rm and req_fp onto the div_* outputs.
  - In half mode, register {16'b0, req_x[15:0]}.
  - Load counter = SETTLE_CYC − 1 and go to EXEC.
- EXEC:
  - div_* held constant.
  - When counter == 0, capture rsp_result (masked to 16 bits if div_fp = 0) and rsp_flags, then go to DONE with rsp_valid = 1.
  - Otherwise decrement the counter.
  - Accept-to-rsp_valid latency = SETTLE_CYC + 1 cycles.
- DONE:
  - rsp_valid held with rsp_result/rsp_flags stable until rsp_ready.
  - On handshake, go to IDLE; rsp_valid falls on the next cycle.
  - No new request is accepted in the handshake cycle. Throughput is one op per SETTLE_CYC + 2 cycles minimum.
- div_* outputs retain their last values after an op completes; they are not cleared.
- Sticky flags:
  - On each rsp handshake, fflags <= fflags | rsp_flags.
  - fflags_clr has priority over the OR: if clear and handshake occur in the same cycle, fflags <= rsp_flags (the new op's flags survive).
  - fflags_clr alone gives fflags <= 0.
- req_valid asserted while not ready: ignored, no side effects. Upstream must hold the request.
- Counter never wraps; SETTLE_CYC outside 1..15 is a configuration error.

Optional Feature:
- FDIV_ISSUE_BYPASS_EN defined:
  - In DONE, a rsp handshake coincident with req_valid accepts the new request in the same cycle (req_ready = rsp_ready in DONE).
  - The new request goes straight to EXEC, giving back-to-back throughput of one op per SETTLE_CYC + 1 cycles.
- Undefined: behaviour exactly as above.

Decomposition:
- Shared package fp_pkg holds:
  - The state enum (IDLE/EXEC/DONE).
  - Flag bit index constants FLG_NV = 4, FLG_DZ = 3, FLG_OF = 2, FLG_UF = 1, FLG_NX = 0.
  - FMT_SINGLE = 1, FMT_HALF = 0.
- One natural sub-module: fflags_acc (sticky register with clear priority). Everything else stays in the top.

Test Plan:
- Test 1, fp32 1.0/2.0:
  - Stimulus: req_a = 3F800000, req_b = 40000000, req_fp = 1, rsp_ready = 1.
  - Response: rsp_valid exactly SETTLE_CYC + 1 cycles after accept; rsp_result = 3F000000; rsp_flags = 00000.
- Test 2, divide by zero:
  - Stimulus: 3F800000 / 00000000.
  - Response: rsp_result = 7F800000; rsp_flags DZ set; fflags = 01000 after handshake.
- Test 3, half mode:
  - Stimulus: req_a = DEAD3C00, req_b = BEEF4000, req_fp = 0.
  - Response: div_op_a = 00003C00; div_op_b = 00004000; rsp_result = 00003800.
- Test 4, backpressure:
  - Stimulus: rsp_ready held 0 for 5 cycles after rsp_valid; second request presented meanwhile.
  - Response: rsp_result stable; req_ready = 0; second op accepted only after the handshake.
- Test 5, reset mid-EXEC:
  - Stimulus: rst pulsed one cycle during EXEC.
  - Response: next cycle state IDLE, rsp_valid = 0, fflags = 0, req_ready = 1; no stale response appears.
- Test 6, clear/handshake collision:
  - Stimulus: fflags = 01000, then fflags_clr coincident with a handshake carrying 00001.
  - Response: fflags = 00001.
